ringbuffer_txn: RTL and testbench

Parametrised successor to the plain ringbuffer: a single-clock, first-word-fall-through ring FIFO with transactional writes. Words shifted in are staged as "pending" and become visible to the reader only on `in_commit`. `in_abort` rolls back everything written since the last commit. It sits between packetising producers (glove sample framers, protocol encoders) and consumers that must never see a partial or corrupted frame. It also reports fill level and an almost-full threshold, so producers can refuse a frame before starting it.

---
 rtl/ringbuffer_txn_pkg.sv | 24 ++
 rtl/ringbuffer_mem.sv | 28 ++
 rtl/ringbuffer_txn.sv | 110 +++++++++++
 tb/tb_ringbuffer_txn.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ringbuffer_txn_pkg.sv
// Shared helpers for the transactional ring FIFO: the count-width function
// and the per-cycle transaction decision type.
package ringbuffer_txn_pkg;

    // Ceiling log2; clog2(1) == 0, so callers ask for clog2(N+1) to hold 0..N.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        TXN_HOLD   = 2'd0,
        TXN_COMMIT = 2'd1,
        TXN_ABORT  = 2'd2
    } txn_op_e;

endpackage

// File: rtl/ringbuffer_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous read.
// Kept separate so a vendor RAM macro can replace it without touching the pointers.
module ringbuffer_mem
    import ringbuffer_txn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ringbuffer_txn.sv
// First-word-fall-through ring FIFO with transactional writes: shifted words stay
// pending until in_commit, and in_abort rewinds the write pointer to the last commit.
module ringbuffer_txn
    import ringbuffer_txn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AFULL = 12,
    localparam int CW   = clog2(DEPTH + 1),
    localparam int PW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_shift,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_commit,
    input  logic             in_abort,
    output logic             full,
    output logic             almost_full,
    input  logic             out_pop,
    output logic [WIDTH-1:0] out_data,
    output logic             empty,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    pending
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0] rd_ptr, cm_ptr, wr_ptr;
    logic [PW-1:0] rd_ptr_n, cm_ptr_n, wr_ptr_n;
    logic [PW-1:0] rd_inc, wr_inc;
    logic [CW-1:0] level_n, pending_n;
    logic [CW-1:0] total;
    logic          sh, pp;
    txn_op_e       op;

    // Flags come only from the registered counts; pointers alone cannot
    // tell full from empty once pending words are involved.
    assign total       = level + pending;
    assign full        = (total == CW'(DEPTH));
    assign almost_full = (total >= CW'(AFULL));
    assign empty       = (level == '0);

    assign sh = in_shift & ~full;
    assign pp = out_pop & ~empty;

    // Explicit wrap so non-power-of-two depths work.
    assign rd_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    assign wr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);

    always_comb begin
        op = TXN_HOLD;
        if (in_abort) begin
            op = TXN_ABORT;
        end else if (in_commit) begin
            op = TXN_COMMIT;
        end
    end

    always_comb begin
        rd_ptr_n  = pp ? rd_inc : rd_ptr;
        cm_ptr_n  = cm_ptr;
        wr_ptr_n  = sh ? wr_inc : wr_ptr;
        level_n   = level - CW'(pp);
        pending_n = pending + CW'(sh);
        case (op)
            TXN_ABORT: begin
                wr_ptr_n  = cm_ptr;
                pending_n = '0;
            end
            TXN_COMMIT: begin
                cm_ptr_n  = sh ? wr_inc : wr_ptr;
                level_n   = level - CW'(pp) + pending + CW'(sh);
                pending_n = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            cm_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            pending <= '0;
        end else begin
            rd_ptr  <= rd_ptr_n;
            cm_ptr  <= cm_ptr_n;
            wr_ptr  <= wr_ptr_n;
            level   <= level_n;
            pending <= pending_n;
        end
    end

    // An aborted word is still written; the rewound wr_ptr overwrites it later.
    ringbuffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (sh),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_ringbuffer_txn.sv
// Bench for ringbuffer_txn at DEPTH=5, WIDTH=8, AFULL=4: directed scenarios
// followed by a random soak against a committed/pending queue model.
module tb_ringbuffer_txn;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int AFULL = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_shift = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_commit = 1'b0;
    logic             in_abort = 1'b0;
    logic             out_pop = 1'b0;
    logic             full, almost_full, empty;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    level, pending;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words visible to the reader, and words staged behind them.
    logic [WIDTH-1:0] m_com[$];
    logic [WIDTH-1:0] m_pen[$];

    ringbuffer_txn #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AFULL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_shift    (in_shift),
        .in_data     (in_data),
        .in_commit   (in_commit),
        .in_abort    (in_abort),
        .full        (full),
        .almost_full (almost_full),
        .out_pop     (out_pop),
        .out_data    (out_data),
        .empty       (empty),
        .level       (level),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; rd is out_data as seen just before the edge.
    task automatic drive(input logic s, input logic [WIDTH-1:0] d, input logic c,
                         input logic a, input logic p, output logic [WIDTH-1:0] rd);
        bit m_full, m_empty;
        m_full  = (m_com.size() + m_pen.size()) == DEPTH;
        m_empty = (m_com.size() == 0);
        in_shift = s; in_data = d; in_commit = c; in_abort = a; out_pop = p;
        rd = out_data;
        @(posedge clk);
        #1;
        in_shift = 1'b0; in_commit = 1'b0; in_abort = 1'b0; out_pop = 1'b0;
        if (p && !m_empty) void'(m_com.pop_front());
        if (s && !m_full) m_pen.push_back(d);
        if (a) begin
            m_pen.delete();
        end else if (c) begin
            foreach (m_pen[i]) m_com.push_back(m_pen[i]);
            m_pen.delete();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_com.delete();
        m_pen.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_com.delete();
        m_pen.delete();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b exp 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %0b exp 0", almost_full); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL reset_pending got %0d exp 0", pending); end
    endtask

    task automatic test_staging();
        logic [WIDTH-1:0] rd;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(10 + i), 1'b0, 1'b0, 1'b0, rd);
            n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL stage_empty got %0b exp 1", empty); end
        end
        n_cmp++; if (pending !== 3'd3) begin n_err++; $display("FAIL stage_pending got %0d exp 3", pending); end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, rd);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL stage_level got %0d exp 3", level); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== 8'(10 + i)) begin n_err++; $display("FAIL stage_read got %0d exp %0d", rd, 10 + i); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL stage_drained got %0b exp 1", empty); end
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] rd;
        logic [WIDTH-1:0] exp_q[$];
        int peak;
        exp_q = '{8'd1, 8'd2, 8'd5};
        peak = 0;
        drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, rd);
        if (int'(level) > peak) peak = int'(level);
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, rd);
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL abort_pending got %0d exp 0", pending); end
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL abort_level got %0d exp 2", level); end
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, rd);
        if (int'(level) > peak) peak = int'(level);
        n_cmp++; if (peak != 3) begin n_err++; $display("FAIL abort_peak got %0d exp 3", peak); end
        foreach (exp_q[i]) begin
            drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== exp_q[i]) begin n_err++; $display("FAIL abort_read got %0d exp %0d", rd, exp_q[i]); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL abort_empty got %0b exp 1", empty); end
    endtask

    task automatic test_full_wrap();
        logic [WIDTH-1:0] rd;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), (i == 4), 1'b0, 1'b0, rd);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got %0b exp 1", full); end
        n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_afull got %0b exp 1", almost_full); end
        n_cmp++; if (level !== 3'd5) begin n_err++; $display("FAIL full_level got %0d exp 5", level); end
        drive(1'b1, 8'd99, 1'b1, 1'b0, 1'b0, rd);
        n_cmp++; if (level !== 3'd5 || pending !== 3'd0) begin n_err++; $display("FAIL full_ignore got %0d/%0d exp 5/0", level, pending); end
        // Pop while full: the slot frees next cycle, the same-cycle shift is dropped.
        drive(1'b1, 8'd77, 1'b1, 1'b0, 1'b1, rd);
        n_cmp++; if (rd !== 8'd0) begin n_err++; $display("FAIL full_pop0 got %0d exp 0", rd); end
        n_cmp++; if (full !== 1'b0 || level !== 3'd4) begin n_err++; $display("FAIL full_release got %0b/%0d exp 0/4", full, level); end
        n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_afull4 got %0b exp 1", almost_full); end
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== 8'(i)) begin n_err++; $display("FAIL full_pop got %0d exp %0d", rd, i); end
        end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL full_afull_clr got %0b exp 0", almost_full); end
        for (int i = 5; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, rd);
            drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== 8'(i)) begin n_err++; $display("FAIL wrap_read got %0d exp %0d", rd, i); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %0b exp 1", empty); end
    endtask

    task automatic test_commit_abort();
        logic [WIDTH-1:0] rd;
        drive(1'b1, 8'd29, 1'b1, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd30, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd31, 1'b0, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd32, 1'b1, 1'b1, 1'b0, rd);
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL ca_pending got %0d exp 0", pending); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL ca_level got %0d exp 1", level); end
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
        n_cmp++; if (rd !== 8'd29 || empty !== 1'b1) begin n_err++; $display("FAIL ca_read got %0d/%0b exp 29/1", rd, empty); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] rd;
        drive(1'b1, 8'd40, 1'b1, 1'b0, 1'b0, rd);
        drive(1'b1, 8'd41, 1'b1, 1'b0, 1'b0, rd);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(42 + i), 1'b1, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== 8'(40 + i)) begin n_err++; $display("FAIL b2b_read got %0d exp %0d", rd, 40 + i); end
            n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level got %0d exp 2", level); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, rd);
            n_cmp++; if (rd !== 8'(46 + i)) begin n_err++; $display("FAIL b2b_drain got %0d exp %0d", rd, 46 + i); end
        end
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] rd;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(60 + i), (i == 2), 1'b0, 1'b0, rd);
        drive(1'b1, 8'd63, 1'b0, 1'b0, 1'b0, rd);
        n_cmp++; if (level !== 3'd3 || pending !== 3'd1) begin n_err++; $display("FAIL mrst_pre got %0d/%0d exp 3/1", level, pending); end
        apply_reset();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty got %0b exp 1", empty); end
        n_cmp++; if (level !== 3'd0 || pending !== 3'd0) begin n_err++; $display("FAIL mrst_counts got %0d/%0d exp 0/0", level, pending); end
    endtask

    task automatic test_soak();
        logic [WIDTH-1:0] rd, exp_head;
        logic s, c, a, p;
        bit had_head;
        for (int n = 0; n < 10000; n++) begin
            s = ($urandom_range(0, 99) < 60);
            c = ($urandom_range(0, 99) < 20);
            a = ($urandom_range(0, 99) < 5);
            p = ($urandom_range(0, 99) < 45);
            had_head = (m_com.size() != 0);
            exp_head = had_head ? m_com[0] : '0;
            drive(s, 8'($urandom_range(0, 255)), c, a, p, rd);
            if (p && had_head) begin
                n_cmp++; if (rd !== exp_head) begin n_err++; $display("FAIL soak_data cyc %0d got %0d exp %0d", n, rd, exp_head); end
            end
            n_cmp++; if (level !== CW'(m_com.size())) begin n_err++; $display("FAIL soak_level cyc %0d got %0d exp %0d", n, level, m_com.size()); end
            n_cmp++; if (pending !== CW'(m_pen.size())) begin n_err++; $display("FAIL soak_pending cyc %0d got %0d exp %0d", n, pending, m_pen.size()); end
            n_cmp++; if (empty !== (m_com.size() == 0)) begin n_err++; $display("FAIL soak_empty cyc %0d got %0b", n, empty); end
            n_cmp++; if (full !== ((m_com.size() + m_pen.size()) == DEPTH)) begin n_err++; $display("FAIL soak_full cyc %0d got %0b", n, full); end
            n_cmp++; if (almost_full !== ((m_com.size() + m_pen.size()) >= AFULL)) begin n_err++; $display("FAIL soak_afull cyc %0d got %0b", n, almost_full); end
        end
    endtask

    initial begin
        test_reset();
        test_staging();
        test_abort();
        test_full_wrap();
        test_commit_abort();
        test_back_to_back();
        test_mid_reset();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
